// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - one-hot stage sequencer with stall, flush, jump, skip, dwell counter and recovery
module stage_sequencer #(
   parameter int NUM_STAGES  = 5,
   parameter int RESET_STAGE = 0,
   parameter int CNT_WIDTH   = 8,
   parameter int IDX_WIDTH   = $clog2(NUM_STAGES)
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic                  advance,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  jump,
   input  logic [IDX_WIDTH-1:0]  jump_idx,
   input  logic [NUM_STAGES-1:0] skip_mask,
   output logic [NUM_STAGES-1:0] stage,
   output logic [IDX_WIDTH-1:0]  stage_idx,
   output logic [CNT_WIDTH-1:0]  stage_cycles,
   output logic                  wrapped,
   output logic                  err
);

   localparam int                  WW      = IDX_WIDTH + 1;
   localparam logic [IDX_WIDTH-1:0] RST_IDX = IDX_WIDTH'(RESET_STAGE);
   localparam logic [NUM_STAGES-1:0] ONE    = NUM_STAGES'(1);
   localparam logic [WW-1:0]       NUM_W   = WW'(NUM_STAGES);

   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
   logic                  wrapped_q, wrapped_d;
   logic                  err_q, err_d;
   logic                  one_hot;
   logic                  jump_oor;
   logic [IDX_WIDTH-1:0]  adv_idx;

   assign one_hot  = (stage_q != '0) && ((stage_q & (stage_q - ONE)) == '0);
   assign jump_oor = ({1'b0, jump_idx} >= NUM_W);
   assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

   // Circular search for the next stage not bypassed; the reset stage is never bypassed.
   always_comb begin
      logic          found;
      logic [WW-1:0] cand_w;
      found   = 1'b0;
      adv_idx = idx_q;
      cand_w  = '0;
      for (int k = 1; k < NUM_STAGES; k++) begin
         cand_w = {1'b0, idx_q} + WW'(k);
         if (cand_w >= NUM_W) begin
            cand_w = cand_w - NUM_W;
         end
         if (!found && ((cand_w[IDX_WIDTH-1:0] == RST_IDX) ||
                        !skip_mask[cand_w[IDX_WIDTH-1:0]])) begin
            found   = 1'b1;
            adv_idx = cand_w[IDX_WIDTH-1:0];
         end
      end
   end

   // Prioritised next-state: recovery > flush > stall > jump > advance > hold.
   always_comb begin
      idx_d     = idx_q;
      cnt_d     = cnt_inc;
      wrapped_d = 1'b0;
      err_d     = 1'b0;
      if (!one_hot) begin
         idx_d = RST_IDX;
         cnt_d = '0;
         err_d = 1'b1;
      end else if (flush) begin
         idx_d = RST_IDX;
         cnt_d = '0;
      end else if (stall) begin
         idx_d = idx_q;
      end else if (jump) begin
         if (jump_oor) begin
            err_d = 1'b1;
         end else begin
            idx_d = jump_idx;
            cnt_d = '0;
         end
      end else if (advance) begin
         idx_d     = adv_idx;
         cnt_d     = '0;
         wrapped_d = (adv_idx <= idx_q);
      end
      stage_d        = '0;
      stage_d[idx_d] = 1'b1;
   end

   // State registers; stage vector and index are loaded from the same next index.
   always_ff @(posedge clk) begin
      if (clear) begin
         stage_q   <= ONE << RESET_STAGE;
         idx_q     <= RST_IDX;
         cnt_q     <= '0;
         wrapped_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         stage_q   <= stage_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         wrapped_q <= wrapped_d;
         err_q     <= err_d;
      end
   end

   assign stage        = stage_q;
   assign stage_idx    = idx_q;
   assign stage_cycles = cnt_q;
   assign wrapped      = wrapped_q;
   assign err          = err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - scoreboard bench for stage_sequencer
module tb_stage_sequencer;

   localparam int N   = 5;
   localparam int R   = 0;
   localparam int CW  = 8;
   localparam int IW  = 3;
   localparam int MAXC = 255;

   logic          clk = 1'b0;
   logic          clear = 1'b0, advance = 1'b0, stall = 1'b0, flush = 1'b0, jump = 1'b0;
   logic [IW-1:0] jump_idx = '0;
   logic [N-1:0]  skip_mask = '0;
   logic [N-1:0]  stage;
   logic [IW-1:0] stage_idx;
   logic [CW-1:0] stage_cycles;
   logic          wrapped, err;

   typedef struct {
      logic [N-1:0]  stg;
      logic [IW-1:0] idx;
      logic [CW-1:0] cyc;
      logic          wr;
      logic          er;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   int   m_idx = R;
   int   m_cyc = 0;
   bit   m_bad = 0;

   stage_sequencer #(.NUM_STAGES(N), .RESET_STAGE(R), .CNT_WIDTH(CW)) dut (
      .clk(clk), .clear(clear), .advance(advance), .stall(stall), .flush(flush),
      .jump(jump), .jump_idx(jump_idx), .skip_mask(skip_mask),
      .stage(stage), .stage_idx(stage_idx), .stage_cycles(stage_cycles),
      .wrapped(wrapped), .err(err)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   // Reference model: the stage is an integer index, the dwell time a plain integer.
   task automatic model(input bit c, a, s, f, j, input int ji, input logic [N-1:0] sk,
                        output exp_t e);
      bit wr = 0;
      bit er = 0;
      if (c) begin
         m_idx = R; m_cyc = 0; m_bad = 0;
      end else if (m_bad) begin
         m_idx = R; m_cyc = 0; er = 1; m_bad = 0;
      end else if (f) begin
         m_idx = R; m_cyc = 0;
      end else if (s) begin
         m_cyc = sat(m_cyc + 1);
      end else if (j) begin
         if (ji < N) begin
            m_idx = ji; m_cyc = 0;
         end else begin
            er = 1; m_cyc = sat(m_cyc + 1);
         end
      end else if (a) begin
         int nw = m_idx;
         for (int k = 1; k < N; k++) begin
            int cnd = (m_idx + k) % N;
            if (cnd == R || !sk[cnd]) begin
               nw = cnd;
               break;
            end
         end
         wr = (nw <= m_idx);
         m_idx = nw;
         m_cyc = 0;
      end else begin
         m_cyc = sat(m_cyc + 1);
      end
      e.stg = N'(1) << m_idx;
      e.idx = IW'(m_idx);
      e.cyc = CW'(m_cyc);
      e.wr  = wr;
      e.er  = er;
   endtask

   task automatic step(input bit c, a, s, f, j, input int ji, input logic [N-1:0] sk,
                       input bit corrupt = 0, input logic [N-1:0] cval = '0);
      exp_t e;
      @(negedge clk);
      if (corrupt) begin
         force dut.stage_q = cval;
         #1;
         release dut.stage_q;
         m_bad = 1;
      end
      clear = c; advance = a; stall = s; flush = f; jump = j;
      jump_idx = IW'(ji); skip_mask = sk;
      model(c, a, s, f, j, ji, sk, e);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Monitor: every edge with an outstanding expectation is compared field by field.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stage", 32'(stage), 32'(e.stg));
            chk("stage_idx", 32'(stage_idx), 32'(e.idx));
            chk("stage_cycles", 32'(stage_cycles), 32'(e.cyc));
            chk("wrapped", 32'(wrapped), 32'(e.wr));
            chk("err", 32'(err), 32'(e.er));
         end
      end
   end

   initial begin
      logic [N-1:0] bad_vals [5];
      bad_vals[0] = 5'b00110; bad_vals[1] = 5'b00000; bad_vals[2] = 5'b11111;
      bad_vals[3] = 5'b10001; bad_vals[4] = 5'b01100;

      // 1: reset then plain advance through all stages and wrap
      step(1, 0, 0, 0, 0, 0, '0);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, '0);

      // 2: skip mask, then all-ones mask keeps reset stage reachable
      step(1, 0, 0, 0, 0, 0, '0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 5'b01010);
      step(0, 1, 0, 0, 0, 0, 5'b11111);
      step(0, 1, 0, 0, 0, 0, 5'b11111);

      // 3: stall beats jump/advance, flush beats stall
      step(0, 0, 0, 0, 1, 2, '0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1, 4, '0);
      step(0, 0, 1, 1, 0, 0, '0);

      // 4: in-range jump, same-stage jump, out-of-range jump
      step(0, 0, 0, 0, 1, 3, '0);
      step(0, 0, 0, 0, 0, 0, '0);
      step(0, 0, 0, 0, 1, 3, '0);
      step(0, 0, 0, 0, 1, 6, '0);
      step(0, 0, 0, 0, 0, 0, '0);

      // 5: corrupted stage register recovers regardless of advance
      step(0, 1, 0, 0, 0, 0, '0, 1, 5'b00110);
      step(0, 0, 0, 0, 0, 0, '0);
      step(0, 1, 0, 0, 0, 0, '0, 1, 5'b00000);
      step(0, 0, 0, 0, 0, 0, '0);

      // 6: dwell counter saturation, then clear wins over flush and jump
      for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 0, 0, '0);
      step(1, 0, 0, 1, 1, 3, '0);
      step(0, 1, 0, 0, 0, 0, '0);

      // Randomised mix of all controls, including occasional corruption
      for (int i = 0; i < 600; i++) begin
         bit c, a, s, f, j, cor;
         c   = ($urandom_range(99) < 3);
         f   = ($urandom_range(99) < 6);
         s   = ($urandom_range(99) < 15);
         j   = ($urandom_range(99) < 15);
         a   = ($urandom_range(99) < 60);
         cor = ($urandom_range(99) < 3);
         step(c, a, s, f, j, int'($urandom_range(7)), N'($urandom), cor,
              bad_vals[$urandom_range(4)]);
      end
      step(0, 0, 0, 0, 0, 0, '0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         failures++;
         $display("FAIL drain actual=%0d expected=0 pending expectations", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
